sprite_layer_fetcher: RTL and testbench

Parametrised per-pixel sprite compositor fetcher for the VPU. On `start` it latches one sprite entry per layer and reads the addressed texel of each valid layer from SDRAM through an Avalon-MM read master, in priority order. It returns the first texel that differs from a programmable transparency key, or a background colour if every layer is transparent or empty. Compared with the previous fetcher it adds a generic layer count, generic sprite size, per-entry horizontal/vertical flip, a programmable key, background fallback, and skipping of empty layers.

---
 rtl/sprite_fetch_pkg.sv | 46 ++++
 rtl/sprite_addr_gen.sv | 34 +++
 rtl/sprite_layer_fetcher.sv | 166 ++++++++++++++++
 tb/tb_sprite_layer_fetcher.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_fetch_pkg.sv
// Shared types and helpers for the sprite layer fetcher.
package sprite_fetch_pkg;

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h0800_0000;

  // ST_EMPTY is the single background cycle taken when no layer is valid.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_EMPTY,
    ST_FINISH
  } state_t;

  // Entry layout, MSB to LSB: {vflip, hflip, id, ox, oy}; oy starts at bit 0.
  function automatic int entry_w(input int id_w, input int dim_log2);
    return id_w + 2 * dim_log2 + 2;
  endfunction

  function automatic int ox_lsb(input int dim_log2);
    return dim_log2;
  endfunction

  function automatic int id_lsb(input int dim_log2);
    return 2 * dim_log2;
  endfunction

  function automatic int hflip_pos(input int dim_log2, input int id_w);
    return 2 * dim_log2 + id_w;
  endfunction

  function automatic int vflip_pos(input int dim_log2, input int id_w);
    return 2 * dim_log2 + id_w + 1;
  endfunction

  // Lowest set bit of mask strictly above idx; -1 when none (idx = -1 searches from 0).
  function automatic int first_valid_above(input logic [31:0] mask, input int idx);
    int found;
    found = -1;
    for (int unsigned i = 0; i < 32; i++) begin
      if (found < 0 && int'(i) > idx && mask[i]) found = int'(i);
    end
    return found;
  endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Maps one sprite entry to the SDRAM byte address of its texel.
module sprite_addr_gen
  import sprite_fetch_pkg::*;
#(
  parameter int          DIM_LOG2  = 4,
  parameter int          ID_W      = 9,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  localparam int         ENTRY_W   = entry_w(ID_W, DIM_LOG2)
) (
  input  logic [ENTRY_W-1:0] entry,
  output logic [31:0]        address
);

  localparam int OX_LSB = ox_lsb(DIM_LOG2);
  localparam int ID_LSB = id_lsb(DIM_LOG2);
  localparam int HF_POS = hflip_pos(DIM_LOG2, ID_W);
  localparam int VF_POS = vflip_pos(DIM_LOG2, ID_W);

  logic [DIM_LOG2-1:0] ox, oy, tx, ty;
  logic [ID_W-1:0]     id;
  logic [31:0]         word;

  // Flip the coordinates, scale the sprite index and convert words to bytes.
  always_comb begin
    oy      = entry[0 +: DIM_LOG2];
    ox      = entry[OX_LSB +: DIM_LOG2];
    id      = entry[ID_LSB +: ID_W];
    tx      = entry[HF_POS] ? ~ox : ox;
    ty      = entry[VF_POS] ? ~oy : oy;
    word    = ((32'(id) - 32'd1) << (2 * DIM_LOG2)) | (32'(ty) << DIM_LOG2) | 32'(tx);
    address = BASE_ADDR + (word << 2);
  end

endmodule

// File: rtl/sprite_layer_fetcher.sv
// Per-pixel sprite compositor fetcher: reads layers in priority order over
// Avalon-MM and returns the first non-transparent texel or the background.
module sprite_layer_fetcher
  import sprite_fetch_pkg::*;
#(
  parameter int          NUM_LAYERS = 4,
  parameter int          DIM_LOG2   = 4,
  parameter int          ID_W       = 9,
  parameter int          PIXEL_W    = 24,
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  localparam int         ENTRY_W    = entry_w(ID_W, DIM_LOG2),
  localparam int         LAYER_W    = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic [NUM_LAYERS*ENTRY_W-1:0] entries,
  input  logic [PIXEL_W-1:0]            transparent_key,
  input  logic [PIXEL_W-1:0]            bg_pixel,
  output logic [31:0]                   address,
  output logic                          read,
  output logic                          chipselect,
  output logic [3:0]                    byteenable,
  input  logic                          waitrequest,
  input  logic                          readdatavalid,
  input  logic [31:0]                   readdata,
  output logic                          busy,
  output logic                          done,
  output logic [PIXEL_W-1:0]            pixel_out,
  output logic                          hit,
  output logic [LAYER_W-1:0]            hit_layer
);

  localparam int ID_LSB = id_lsb(DIM_LOG2);

  state_t                        state;
  logic [NUM_LAYERS*ENTRY_W-1:0] lat_entries;
  logic [PIXEL_W-1:0]            lat_key;
  logic [PIXEL_W-1:0]            lat_bg;
  logic [LAYER_W-1:0]            cur_layer;
  logic [31:0]                   in_mask, lat_mask;
  int                            first_in, next_lat, sel_i;
  logic [ENTRY_W-1:0]            gen_entry;
  logic [31:0]                   gen_addr;
  logic [PIXEL_W-1:0]            texel;
  logic                          unused_rd;

  assign byteenable = 4'b1111;
  assign texel      = readdata[PIXEL_W-1:0];
  assign unused_rd  = ^readdata;

  // Valid-layer masks for the incoming and latched entries, and the next layer to fetch.
  always_comb begin
    in_mask  = '0;
    lat_mask = '0;
    for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
      in_mask[k]  = |entries[k*ENTRY_W + ID_LSB +: ID_W];
      lat_mask[k] = |lat_entries[k*ENTRY_W + ID_LSB +: ID_W];
    end
    first_in = first_valid_above(in_mask, -1);
    next_lat = first_valid_above(lat_mask, int'(cur_layer));
  end

  // One address generator: fed from the live entries in IDLE, else from the latched set.
  always_comb begin
    gen_entry = '0;
    sel_i     = (state == ST_IDLE) ? first_in : next_lat;
    for (int unsigned k = 0; k < NUM_LAYERS; k++) begin
      if (int'(k) == sel_i)
        gen_entry = (state == ST_IDLE) ? entries[k*ENTRY_W +: ENTRY_W]
                                       : lat_entries[k*ENTRY_W +: ENTRY_W];
    end
  end

  sprite_addr_gen #(
    .DIM_LOG2  (DIM_LOG2),
    .ID_W      (ID_W),
    .BASE_ADDR (BASE_ADDR)
  ) u_addr_gen (
    .entry   (gen_entry),
    .address (gen_addr)
  );

  // Fetch FSM with registered bus strobes and results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      lat_entries <= '0;
      lat_key     <= '0;
      lat_bg      <= '0;
      cur_layer   <= '0;
      address     <= '0;
      read        <= 1'b0;
      chipselect  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pixel_out   <= '0;
      hit         <= 1'b0;
      hit_layer   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            lat_entries <= entries;
            lat_key     <= transparent_key;
            lat_bg      <= bg_pixel;
            busy        <= 1'b1;
            if (first_in >= 0) begin
              cur_layer  <= LAYER_W'(first_in);
              address    <= gen_addr;
              read       <= 1'b1;
              chipselect <= 1'b1;
              state      <= ST_ISSUE;
            end else begin
              state <= ST_EMPTY;
            end
          end
        end
        ST_ISSUE: begin
          if (!waitrequest) begin
            read       <= 1'b0;
            chipselect <= 1'b0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (readdatavalid) begin
            if (texel != lat_key) begin
              pixel_out <= texel;
              hit       <= 1'b1;
              hit_layer <= cur_layer;
              done      <= 1'b1;
              state     <= ST_FINISH;
            end else if (next_lat >= 0) begin
              cur_layer  <= LAYER_W'(next_lat);
              address    <= gen_addr;
              read       <= 1'b1;
              chipselect <= 1'b1;
              state      <= ST_ISSUE;
            end else begin
              pixel_out <= lat_bg;
              hit       <= 1'b0;
              hit_layer <= '0;
              done      <= 1'b1;
              state     <= ST_FINISH;
            end
          end
        end
        ST_EMPTY: begin
          pixel_out <= lat_bg;
          hit       <= 1'b0;
          hit_layer <= '0;
          done      <= 1'b1;
          state     <= ST_FINISH;
        end
        ST_FINISH: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_layer_fetcher.sv
// Directed bench for sprite_layer_fetcher with an Avalon slave and a layer-walk model.
module tb_sprite_layer_fetcher;

  localparam int NL  = 4;
  localparam int EW  = 19;
  localparam int PW  = 24;
  localparam logic [31:0] BASE = 32'h0800_0000;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic [NL*EW-1:0] entries;
  logic [PW-1:0]   transparent_key;
  logic [PW-1:0]   bg_pixel;
  logic [31:0]     address;
  logic            read;
  logic            chipselect;
  logic [3:0]      byteenable;
  logic            waitrequest;
  logic            readdatavalid;
  logic [31:0]     readdata;
  logic            busy;
  logic            done;
  logic [PW-1:0]   pixel_out;
  logic            hit;
  logic [1:0]      hit_layer;

  sprite_layer_fetcher #(
    .NUM_LAYERS (NL),
    .DIM_LOG2   (4),
    .ID_W       (9),
    .PIXEL_W    (PW),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .entries         (entries),
    .transparent_key (transparent_key),
    .bg_pixel        (bg_pixel),
    .address         (address),
    .read            (read),
    .chipselect      (chipselect),
    .byteenable      (byteenable),
    .waitrequest     (waitrequest),
    .readdatavalid   (readdatavalid),
    .readdata        (readdata),
    .busy            (busy),
    .done            (done),
    .pixel_out       (pixel_out),
    .hit             (hit),
    .hit_layer       (hit_layer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cycles = 0;
  int extra_lat = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] acc_log [$];

  logic [31:0] exp_addrs [$];
  logic [PW-1:0] exp_pix, prev_pix;
  logic          exp_hit, prev_hit;
  logic [1:0]    exp_layer, prev_layer;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h00DE_AD00;
  endfunction

  function automatic logic [EW-1:0] mk(input logic v, input logic h, input int id,
                                       input int ox, input int oy);
    return {v, h, 9'(id), 4'(ox), 4'(oy)};
  endfunction

  // Avalon slave: W waitrequest cycles per read, then data 1+X cycles after acceptance.
  initial begin
    int wcnt;
    int lcnt;
    logic [31:0] pend;
    wcnt = 0;
    lcnt = 0;
    pend = '0;
    waitrequest   = 1'b0;
    readdatavalid = 1'b0;
    readdata      = '0;
    forever begin
      @(negedge clk);
      readdatavalid = 1'b0;
      if (!rst_n) begin
        wcnt = 0;
        lcnt = 0;
        waitrequest = 1'b0;
      end else begin
        if (lcnt > 0) begin
          lcnt--;
          if (lcnt == 0) begin
            readdatavalid = 1'b1;
            readdata      = pend;
          end
        end
        if (read && chipselect) begin
          if (wcnt < wr_cycles) begin
            waitrequest = 1'b1;
            wcnt++;
          end else begin
            waitrequest = 1'b0;
            wcnt = 0;
            pend = mem_rd(address);
            lcnt = 1 + extra_lat;
            acc_log.push_back(address);
          end
        end else begin
          waitrequest = 1'b0;
        end
      end
    end
  end

  // Walk the layers in priority order: which texels are read and which one wins.
  task automatic model(input logic [NL*EW-1:0] ents, input logic [PW-1:0] key,
                       input logic [PW-1:0] bg);
    exp_addrs.delete();
    exp_pix   = bg;
    exp_hit   = 1'b0;
    exp_layer = 2'd0;
    for (int k = 0; k < NL; k++) begin
      logic [EW-1:0] e;
      int id, ox, oy, tx, ty;
      logic [31:0] a, d;
      e  = ents[k*EW +: EW];
      id = int'(e[16:8]);
      ox = int'(e[7:4]);
      oy = int'(e[3:0]);
      if (id == 0) continue;
      tx = e[17] ? 15 - ox : ox;
      ty = e[18] ? 15 - oy : oy;
      a  = BASE + 32'(4 * ((id - 1) * 256 + ty * 16 + tx));
      exp_addrs.push_back(a);
      d = mem_rd(a);
      if (d[PW-1:0] != key) begin
        exp_pix   = d[PW-1:0];
        exp_hit   = 1'b1;
        exp_layer = 2'(k);
        break;
      end
    end
  endtask

  // One transaction, checked every cycle from the start cycle to three cycles past done.
  task automatic run_txn(input string tag, input logic [NL*EW-1:0] ents,
                         input logic [PW-1:0] key, input logic [PW-1:0] bg,
                         input int w, input int x, input int pulse_c,
                         input logic [31:0] lit_addr, input int lit_done);
    int n, p, d;
    logic eb, ed, er;
    logic [31:0] ea;
    wr_cycles = w;
    extra_lat = x;
    model(ents, key, bg);
    n = exp_addrs.size();
    p = 2 + w + x;
    d = (n == 0) ? 2 : 1 + n * p;
    acc_log.delete();
    for (int c = 0; c <= d + 3; c++) begin
      @(negedge clk);
      eb = (c >= 1 && c <= d);
      ed = (c == d);
      er = 1'b0;
      ea = '0;
      for (int j = 0; j < n; j++) begin
        if (c >= 1 + j * p && c <= 1 + j * p + w) begin
          er = 1'b1;
          ea = exp_addrs[j];
        end
      end
      chk({tag, ":ctl"}, 64'({busy, done, read, chipselect}), 64'({eb, ed, er, er}));
      if (er) chk({tag, ":addr"}, 64'(address), 64'(ea));
      if (c >= d)
        chk({tag, ":result"}, 64'({pixel_out, hit, hit_layer}), 64'({exp_pix, exp_hit, exp_layer}));
      else
        chk({tag, ":held"}, 64'({pixel_out, hit, hit_layer}), 64'({prev_pix, prev_hit, prev_layer}));
      if (c == 1 && lit_addr != 32'd0) chk({tag, ":lit_addr"}, 64'(address), 64'(lit_addr));
      if (c == lit_done) chk({tag, ":lit_done"}, 64'(done), 64'd1);
      if (c == 0) begin
        entries         = ents;
        transparent_key = key;
        bg_pixel        = bg;
        start           = 1'b1;
      end else begin
        start = (c == pulse_c);
      end
    end
    chk({tag, ":nreads"}, 64'(acc_log.size()), 64'(n));
    prev_pix   = exp_pix;
    prev_hit   = exp_hit;
    prev_layer = exp_layer;
  endtask

  initial begin
    logic [EW-1:0] z;
    z = '0;
    rst_n = 1'b0;
    start = 1'b0;
    entries = '0;
    transparent_key = '0;
    bg_pixel = '0;
    prev_pix = '0;
    prev_hit = 1'b0;
    prev_layer = 2'd0;
    #1;
    chk("reset_ctl", 64'({address, read, chipselect, byteenable, busy, done}), 64'({32'd0, 1'b0, 1'b0, 4'hF, 1'b0, 1'b0}));
    chk("reset_res", 64'({pixel_out, hit, hit_layer}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    mem[32'h0800_00C8] = 32'h7FFF_0000;
    mem[32'h0800_00F4] = 32'h0000_0001;
    mem[32'h0800_0308] = 32'h00C0_FFEE;
    run_txn("t1", {z, z, z, mk(0, 0, 1, 2, 3)}, 24'h0, 24'h0, 0, 0, -1, 32'h0800_00C8, 3);
    chk("t1_pix", 64'({pixel_out, hit, hit_layer}), 64'({24'hFF0000, 1'b1, 2'd0}));
    run_txn("t2_hflip", {z, z, z, mk(0, 1, 1, 2, 3)}, 24'h0, 24'h0, 0, 0, -1, 32'h0800_00F4, 3);
    run_txn("t3_vflip", {z, z, z, mk(1, 0, 1, 2, 3)}, 24'h0, 24'h0, 0, 0, -1, 32'h0800_0308, 3);

    mem[32'h0800_00C8] = 32'h00FF_00FF;
    mem[32'h0800_0400] = 32'h0012_3456;
    run_txn("t4_skip", {z, mk(0, 0, 2, 0, 0), z, mk(0, 0, 1, 2, 3)}, 24'hFF00FF, 24'h0, 0, 0, -1, 32'h0800_00C8, 5);
    chk("t4_pix", 64'({pixel_out, hit, hit_layer}), 64'({24'h123456, 1'b1, 2'd2}));

    run_txn("t5_empty", {z, z, z, z}, 24'h0, 24'h0A0B0C, 0, 0, -1, 32'h0, 2);
    chk("t5_pix", 64'({pixel_out, hit, hit_layer}), 64'({24'h0A0B0C, 1'b0, 2'd0}));

    mem[32'h0800_1380] = 32'h00AB_CDEF;
    run_txn("t6_wait", {mk(1, 1, 5, 15, 1), z, z, z}, 24'h0, 24'h0, 3, 0, 2, 32'h0800_1380, 6);

    mem[32'h0800_0800] = 32'hFF55_5555;
    mem[32'h0800_0C44] = 32'hFF55_5555;
    run_txn("t7_bg", {z, z, mk(0, 0, 4, 1, 1), mk(0, 0, 3, 0, 0)}, 24'h555555, 24'h010203, 0, 1, 7, 32'h0800_0800, 7);

    mem[32'h0807_FBFC] = 32'h0000_0001;
    run_txn("t8_maxid", {z, z, mk(0, 0, 1, 0, 0), mk(0, 0, 511, 15, 15)}, 24'h0, 24'h0, 0, 0, -1, 32'h0807_FBFC, 3);

    // Reset while the read is outstanding.
    mem[32'h0800_00C8] = 32'h7FFF_0000;
    wr_cycles = 0;
    extra_lat = 4;
    @(negedge clk);
    entries = {z, z, z, mk(0, 0, 1, 2, 3)};
    transparent_key = 24'h0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async", 64'({read, chipselect, busy, done, pixel_out, hit}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_pix = '0;
    prev_hit = 1'b0;
    prev_layer = 2'd0;
    run_txn("t9_after_rst", {z, z, z, mk(0, 0, 1, 2, 3)}, 24'h0, 24'h0, 0, 0, -1, 32'h0800_00C8, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
